// File: rtl/mux.sv
// 2:1 multiplexer of DW-bit inputs, with a registered output copy and select-change tracking.
// Build macro MUX_REG_OUT_EN: defined -> y_q is a flop of Y; undefined -> y_q is wired to Y.
module mux #(
    parameter int DW    = 1,
    parameter int CNT_W = 8
) (
    output logic [DW-1:0]    Y,
    input  logic [2*DW-1:0]  I,
    input  logic             S,
    input  logic             clk,
    input  logic             rst_n,
    output logic [DW-1:0]    y_q,
    output logic             sel_chg,
    output logic [CNT_W-1:0] sel_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             s_q;
    logic             s_d;
    logic             sel_chg_q;
    logic             sel_chg_d;
    logic [CNT_W-1:0] sel_cnt_q;
    logic [CNT_W-1:0] sel_cnt_d;

    // Each output bit is an independent 2:1 select.
    for (genvar gi = 0; gi < DW; gi++) begin : g_bit
        assign Y[gi] = S ? I[DW + gi] : I[gi];
    end

    // An X/Z select makes the inequality unknown, so the if falls through to "no change".
    always_comb begin
        s_d       = S;
        sel_chg_d = 1'b0;
        sel_cnt_d = sel_cnt_q;
        if (S != s_q) begin
            sel_chg_d = 1'b1;
            if (sel_cnt_q != CNT_MAX) begin
                sel_cnt_d = sel_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q       <= 1'b0;
            sel_chg_q <= 1'b0;
            sel_cnt_q <= '0;
        end else begin
            s_q       <= s_d;
            sel_chg_q <= sel_chg_d;
            sel_cnt_q <= sel_cnt_d;
        end
    end

    assign sel_chg = sel_chg_q;
    assign sel_cnt = sel_cnt_q;

`ifdef MUX_REG_OUT_EN
    logic [DW-1:0] y_d;

    assign y_d = Y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end
`else
    assign y_q = Y;
`endif

endmodule

// File: tb/tb_mux.sv
// Bench for mux: directed steps followed by randomized traffic, checked against an
// arithmetic reference model; one narrow instance (DW=1) and one wide, saturating (DW=8, CNT_W=2).
module tb_mux;

`ifdef MUX_REG_OUT_EN
    localparam bit REG = 1'b1;
`else
    localparam bit REG = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        run_clk;
    logic        S;
    logic [1:0]  I1;
    logic [15:0] I2;
    logic        Y1;
    logic        yq1;
    logic        chg1;
    logic [7:0]  cnt1;
    logic [7:0]  Y2;
    logic [7:0]  yq2;
    logic        chg2;
    logic [1:0]  cnt2;

    int checks;
    int errors;

    // Reference model state
    int s_prev;
    int m_cnt1;
    int m_cnt2;
    int m_chg;
    int m_yq1;
    int m_yq2;

    mux #(.DW(1), .CNT_W(8)) dut1 (
        .Y(Y1), .I(I1), .S(S), .clk(clk), .rst_n(rst_n),
        .y_q(yq1), .sel_chg(chg1), .sel_cnt(cnt1)
    );

    mux #(.DW(8), .CNT_W(2)) dut2 (
        .Y(Y2), .I(I2), .S(S), .clk(clk), .rst_n(rst_n),
        .y_q(yq2), .sel_chg(chg2), .sel_cnt(cnt2)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (run_clk) clk = ~clk;
    end

    function automatic int ref_y1();
        return (int'(I1) >> (int'(S) * 1)) % 2;
    endfunction

    function automatic int ref_y2();
        return (int'(I2) >> (int'(S) * 8)) % 256;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        s_prev = 0; m_cnt1 = 0; m_cnt2 = 0; m_chg = 0; m_yq1 = 0; m_yq2 = 0;
    endtask

    task automatic model_edge();
        if (rst_n === 1'b1) begin
            m_chg = (int'(S) != s_prev) ? 1 : 0;
            if (m_chg == 1) begin
                m_cnt1 = (m_cnt1 + 1 > 255) ? 255 : m_cnt1 + 1;
                m_cnt2 = (m_cnt2 + 1 > 3) ? 3 : m_cnt2 + 1;
            end
            s_prev = int'(S);
            m_yq1  = ref_y1();
            m_yq2  = ref_y2();
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_y1"},   32'(Y1),   32'(ref_y1()));
        chk({tag, "_y2"},   32'(Y2),   32'(ref_y2()));
        chk({tag, "_yq1"},  32'(yq1),  32'(REG ? m_yq1 : ref_y1()));
        chk({tag, "_yq2"},  32'(yq2),  32'(REG ? m_yq2 : ref_y2()));
        chk({tag, "_chg1"}, 32'(chg1), 32'(m_chg));
        chk({tag, "_chg2"}, 32'(chg2), 32'(m_chg));
        chk({tag, "_cnt1"}, 32'(cnt1), 32'(m_cnt1));
        chk({tag, "_cnt2"}, 32'(cnt2), 32'(m_cnt2));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        run_clk = 1'b0;
        rst_n = 1'b0;
        S = 1'b0;
        I1 = 2'b00;
        I2 = 16'h0000;
        model_reset();
        #1;
        check_all("reset");

        // Combinational truth steps with the clock idle
        rst_n = 1'b1;
        I1 = 2'b00; S = 1'b0; I2 = 16'hA55A; #5; chk("d026_s0", 32'(Y1), 32'd0); check_all("d026_s0"); #5;
        I1 = 2'b01; S = 1'b0; I2 = 16'h3CC3; #5; chk("d026_s1", 32'(Y1), 32'd1); #5;
        I1 = 2'b10; S = 1'b1; I2 = 16'h7E81; #5; chk("d026_s2", 32'(Y1), 32'd1); chk("d026_s2_y2", 32'(Y2), 32'h7E); #5;
        I1 = 2'b11; S = 1'b1; #5; chk("d026_s3", 32'(Y1), 32'd1); #5;

        // Select toggles with no clock: Y follows at once
        I1 = 2'b10;
        S = 1'b0; #1; chk("d027_a", 32'(Y1), 32'd0);
        S = 1'b1; #1; chk("d027_b", 32'(Y1), 32'd1);
        S = 1'b0; #1; chk("d027_c", 32'(Y1), 32'd0);

        // Output latency: before and after the first edge
        I1 = 2'b01; S = 1'b0; #1;
        chk("d028_pre", 32'(yq1), 32'(REG ? 0 : 1));
        run_clk = 1'b1;
        tick();
        chk("d028_post", 32'(yq1), 32'd1);
        check_all("d028");

        // Five toggles on consecutive edges
        for (int k = 0; k < 5; k++) begin
            S = ~S;
            tick();
            check_all("d029_tog");
        end
        chk("d029_cnt8", 32'(cnt1), 32'd5);
        chk("d029_cnt2", 32'(cnt2), 32'd3);

        // Reset between edges with a pulse pending
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("d030_rst");
        S = 1'b0; I1 = 2'b01; I2 = 16'h12EF; #1;
        chk("d030_y1", 32'(Y1), 32'd1);
        chk("d030_y2", 32'(Y2), 32'hEF);
        tick();
        check_all("d030_hold");

        // First edge after release: S=1 counts against reset value 0
        S = 1'b1;
        rst_n = 1'b1;
        tick();
        check_all("d021_first");
        chk("d021_cnt", 32'(cnt1), 32'd1);
        tick();
        check_all("d021_nochg");

        // Randomized traffic with occasional mid-cycle resets
        for (int n = 0; n < 200; n++) begin
            I1 = 2'($urandom);
            I2 = 16'($urandom);
            if ($urandom_range(0, 2) != 0) S = 1'($urandom);
            #1;
            chk("rnd_comb_y1", 32'(Y1), 32'(ref_y1()));
            chk("rnd_comb_y2", 32'(Y2), 32'(ref_y2()));
            if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                check_all("rnd_rst");
                rst_n = 1'b1;
            end
            tick();
            check_all("rnd_edge");
            $display("txn %0d S=%0d I1=%0h I2=%0h cnt1=%0d cnt2=%0d chg=%0d",
                     n, S, I1, I2, cnt1, cnt2, chg1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux.md
MUX -- requirements
Module: mux

Interface
REQ-001 Parameter DW, default 1: data width of each mux input and of the output.
REQ-002 Parameter CNT_W, default 8: width of the select-toggle counter.
REQ-003 Port clk  input  1  clock; all sequential logic on its rising edge.
REQ-004 Port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 Port Y  output  DW  combinational mux output.
REQ-006 Port I  input  2*DW  data inputs: I[DW-1:0] is input 0, I[2*DW-1:DW] is input 1.
REQ-007 Port S  input  1  select: 0 picks input 0, 1 picks input 1.
REQ-008 Port y_q  output  DW  registered copy of Y.
REQ-009 Port sel_chg  output  1  one-cycle pulse on a registered change of S.
REQ-010 Port sel_cnt  output  CNT_W  saturating count of S changes since reset.
REQ-011 Port declaration order SHALL be Y, I, S, clk, rst_n, y_q, sel_chg, sel_cnt, so that three-port positional instantiation (Y, I, S) binds correctly; clk and rst_n SHALL be tied off in such benches.

Function
REQ-012 Y SHALL equal I[DW-1:0] when S=0 and I[2*DW-1:DW] when S=1, purely combinationally: zero latency, no clock dependence, valid in the same delta after any I or S change.
REQ-013 Y SHALL be independent of clk and rst_n, including while rst_n=0.
REQ-014 y_q SHALL load Y on every rising clk edge while rst_n=1, giving one-cycle latency.
REQ-015 A register s_q SHALL capture S every rising clk edge; sel_chg SHALL be 1 for exactly the cycle after s_q differs from S at a clock edge, else 0.
REQ-016 sel_cnt SHALL increment by 1 on each edge where S != s_q, and SHALL hold at 2^CNT_W-1 (no wrap).
REQ-017 A select change and a data change in the same cycle SHALL both take effect: y_q reflects the new selection of the new data.
REQ-018 An unknown (X/Z) S SHALL be treated as "no change" for sel_cnt and sel_chg; Y behaviour under unknown S is unconstrained.

Reset
REQ-019 On rst_n falling, y_q, s_q, sel_chg and sel_cnt SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-020 While rst_n=0, these registers SHALL hold 0; Y continues to follow REQ-012.
REQ-021 After rst_n rises, the first clk edge SHALL update registers normally; an S=1 at that edge counts as a change from the reset value 0.
REQ-022 Reset asserted mid-operation SHALL discard the count and any pending sel_chg pulse.

Configuration
REQ-023 Macro MUX_REG_OUT_EN: when defined, y_q SHALL be the registered output of REQ-014.
REQ-024 When MUX_REG_OUT_EN is undefined, y_q SHALL be driven combinationally equal to Y, and no y_q flop SHALL be inferred.
REQ-025 sel_chg and sel_cnt behaviour SHALL be identical with and without MUX_REG_OUT_EN.

Verification
REQ-026 DW=1, clk and rst_n idle: apply I=00,S=0 -> Y=0; then I=01,S=0 -> Y=1; then I=10,S=1 -> Y=1; then I=11,S=1 -> Y=1; hold each step 10 ns and check Y within that step.
REQ-027 I=10, toggle S 0->1->0 with no clock -> Y goes 0->1->0 immediately after each toggle.
REQ-028 MUX_REG_OUT_EN defined, rst_n=1: I=01, S=0, then clock once -> y_q=1 after the edge and 0 before it; with the macro undefined -> y_q=1 immediately.
REQ-029 Toggle S on 5 consecutive clock edges -> sel_cnt=5, with one sel_chg pulse per toggle; with CNT_W=2, 5 toggles -> sel_cnt=3 (saturated).
REQ-030 With sel_cnt=3, assert rst_n=0 between clock edges -> sel_cnt, sel_chg and y_q read 0 before the next edge, while Y still follows I and S.
